// File: rtl/piezo_arb_pkg.sv
// piezo_arb_pkg: shared widths, FSM state encoding and one-hot helper for the piezo play arbiter
package piezo_arb_pkg;
    localparam int NUM_REQ = 3;
    localparam int BS_W    = 128;
    localparam int LEN_W   = 9;
    localparam int T_W     = 32;

    typedef enum logic [2:0] {IDLE, START, PLAY, DRAIN, GUARD} state_t;

    function automatic logic [1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/piezo_arb_pick.sv
// piezo_arb_pick: combinational winner pick, first requester at or after the pointer wins
module piezo_arb_pick
    import piezo_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_win,
    output logic               o_valid
);
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_oh;

    // rotate so the pointer index sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        w_rot   = i_ptr == 2'd1 ? {i_req[0], i_req[2:1]} : i_ptr == 2'd2 ? {i_req[1:0], i_req[2]} : i_req;
        w_oh    = w_rot & (~w_rot + 3'd1);
        o_win   = i_ptr == 2'd1 ? {w_oh[1:0], w_oh[2]} : i_ptr == 2'd2 ? {w_oh[0], w_oh[2:1]} : w_oh;
        o_valid = |i_req;
    end
endmodule

// File: rtl/piezo_play_arbiter.sv
// piezo_play_arbiter: shares one Morse player among three requesters; define PIEZO_ARB_RR_EN for round-robin
module piezo_play_arbiter
    import piezo_arb_pkg::*;
#(
    parameter logic [31:0] GUARD_CYCLES = 32'd2_500_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*BS_W-1:0]  req_bitstream,
    input  logic [NUM_REQ*LEN_W-1:0] req_bit_length,
    input  logic [NUM_REQ*T_W-1:0]   req_dit,
    input  logic [NUM_REQ*T_W-1:0]   req_dah,
    input  logic [NUM_REQ*T_W-1:0]   req_gap,
    input  logic                   player_busy,
    input  logic                   player_done,
    input  logic                   piezo_in,
    output logic                   player_start,
    output logic [BS_W-1:0]        player_bitstream,
    output logic [LEN_W-1:0]       player_bit_length,
    output logic [T_W-1:0]         player_dit,
    output logic [T_W-1:0]         player_dah,
    output logic [T_W-1:0]         player_gap,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done_pulse,
    output logic [NUM_REQ-1:0]     abort_pulse,
    output logic                   piezo_out
);
    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic [NUM_REQ-1:0] r_abort, w_abort_nxt;
    logic               r_start;
    logic [31:0]        r_cnt;
    logic [BS_W-1:0]    r_bs;
    logic [LEN_W-1:0]   r_len;
    logic [T_W-1:0]     r_dit, r_dah, r_gap;
    logic [NUM_REQ-1:0] w_win;
    logic               w_valid;
    logic [1:0]         w_ptr;
    logic [1:0]         w_idx;
    logic               w_latch;
    logic               w_own_req;
    logic               w_fin;
    logic               w_guard_end;

`ifdef PIEZO_ARB_RR_EN
    logic [1:0] r_ptr;

    // pointer moves to the index just after each winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 2'd0;
        else if (w_latch)
            r_ptr <= w_idx == 2'd2 ? 2'd0 : w_idx + 2'd1;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    piezo_arb_pick u_pick (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_idx       = oh2idx(w_win);
    assign w_latch     = r_state == IDLE && w_valid;
    assign w_own_req   = |(req & r_grant);
    // r_start is high exactly in the first PLAY cycle; an idle player there means nothing to wait for
    assign w_fin       = player_done || (r_start && !player_busy);
    assign w_guard_end = ({1'b0, r_cnt} + 33'd1) >= {1'b0, GUARD_CYCLES};

    // next-state and next pulse/grant values
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_abort_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = START;
                    w_grant_nxt = w_win;
                end
            end
            START: w_state_nxt = PLAY;
            PLAY: begin
                if (w_fin) begin
                    w_done_nxt  = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = GUARD;
                end else if (!w_own_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (player_done) begin
                    w_abort_nxt = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = GUARD;
                end
            end
            GUARD: w_state_nxt = w_guard_end ? IDLE : GUARD;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, grant, pulses and guard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_abort <= '0;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            r_start <= r_state == START;
            r_cnt   <= r_state == GUARD ? r_cnt + 32'd1 : '0;
        end
    end

    // player parameters are captured only on an arbitration win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bs  <= '0;
            r_len <= '0;
            r_dit <= '0;
            r_dah <= '0;
            r_gap <= '0;
        end else if (w_latch) begin
            r_bs  <= req_bitstream[int'(w_idx)*BS_W +: BS_W];
            r_len <= req_bit_length[int'(w_idx)*LEN_W +: LEN_W];
            r_dit <= req_dit[int'(w_idx)*T_W +: T_W];
            r_dah <= req_dah[int'(w_idx)*T_W +: T_W];
            r_gap <= req_gap[int'(w_idx)*T_W +: T_W];
        end
    end

    assign player_start      = r_start;
    assign player_bitstream  = r_bs;
    assign player_bit_length = r_len;
    assign player_dit        = r_dit;
    assign player_dah        = r_dah;
    assign player_gap        = r_gap;
    assign grant             = r_grant;
    assign done_pulse        = r_done;
    assign abort_pulse       = r_abort;
    assign piezo_out         = (r_state == START || r_state == PLAY) && piezo_in;
endmodule

// File: tb/tb_piezo_play_arbiter.sv
// tb_piezo_play_arbiter: table, directed and randomized checks of the piezo play arbiter
module tb_piezo_play_arbiter;
    localparam int G = 10;
`ifdef PIEZO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   req = '0;
    logic [383:0] bs = '0;
    logic [26:0]  len = '0;
    logic [95:0]  dit = '0, dah = '0, gap = '0;
    logic         busy = 1'b0, pdone = 1'b0, pin = 1'b0;

    logic         a_start, b_start;
    logic [127:0] a_bs, b_bs;
    logic [8:0]   a_len, b_len;
    logic [31:0]  a_dit, a_dah, a_gap, b_dit, b_dah, b_gap;
    logic [2:0]   a_grant, a_done, a_abort, b_grant, b_done, b_abort;
    logic         a_pout, b_pout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piezo_play_arbiter #(.GUARD_CYCLES(32'd10)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .req_bitstream(bs), .req_bit_length(len),
        .req_dit(dit), .req_dah(dah), .req_gap(gap), .player_busy(busy), .player_done(pdone),
        .piezo_in(pin), .player_start(a_start), .player_bitstream(a_bs), .player_bit_length(a_len),
        .player_dit(a_dit), .player_dah(a_dah), .player_gap(a_gap), .grant(a_grant),
        .done_pulse(a_done), .abort_pulse(a_abort), .piezo_out(a_pout)
    );

    piezo_play_arbiter #(.GUARD_CYCLES(32'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .req_bitstream(bs), .req_bit_length(len),
        .req_dit(dit), .req_dah(dah), .req_gap(gap), .player_busy(busy), .player_done(pdone),
        .piezo_in(pin), .player_start(b_start), .player_bitstream(b_bs), .player_bit_length(b_len),
        .player_dit(b_dit), .player_dah(b_dah), .player_gap(b_gap), .grant(b_grant),
        .done_pulse(b_done), .abort_pulse(b_abort), .piezo_out(b_pout)
    );

    typedef struct {
        logic [2:0] r;
        logic [2:0] g;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        pdone = 1'b0;
        busy  = 1'b0;
        pin   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy  = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 12; i++) bs[i*32 +: 32] = $urandom;
        len = 27'($urandom);
        for (int i = 0; i < 3; i++) begin
            dit[i*32 +: 32] = $urandom;
            dah[i*32 +: 32] = $urandom;
            gap[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic wait_grant(input bit use_b, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((use_b ? b_grant : a_grant) != 3'b000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk({name, "_grant_timeout"}, 0, 1);
    endtask

    // reference winner: scan requesters starting at the pointer
    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return 0;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, ptr, cnt, ones, mode, k;
        bit silent;
        logic [2:0] r, exp_rr [4];
        logic [31:0] saved;

        tbl[0] = '{3'b001, 3'b001};
        tbl[1] = '{3'b010, 3'b010};
        tbl[2] = '{3'b011, 3'b001};
        tbl[3] = '{3'b100, 3'b100};
        tbl[4] = '{3'b101, 3'b001};
        tbl[5] = '{3'b110, 3'b010};
        tbl[6] = '{3'b111, 3'b001};

        rst_n = 1'b0;
        #3;
        chk("rst_grant", a_grant, 0);
        chk("rst_start", a_start, 0);
        chk("rst_bs", a_bs, 0);
        chk("rst_dit", a_dit, 0);
        chk("rst_pout", a_pout, 0);

        // table: first win from reset, latency and latched slice
        for (int i = 0; i < 7; i++) begin
            do_reset();
            rand_data();
            req = tbl[i].r;
            w = tbl[i].g[0] ? 0 : tbl[i].g[1] ? 1 : 2;
            @(negedge clk);
            chk("tbl_grant", a_grant, tbl[i].g);
            chk("tbl_start_early", a_start, 0);
            chk("tbl_bs", a_bs, bs[w*128 +: 128]);
            chk("tbl_len", a_len, len[w*9 +: 9]);
            chk("tbl_dah", a_dah, dah[w*32 +: 32]);
            @(negedge clk);
            chk("tbl_start", a_start, 1);
            @(negedge clk);
            chk("tbl_start_once", a_start, 0);
        end

        // done with request held: one done pulse, G guard cycles plus idle, then re-grant
        do_reset();
        rand_data();
        req = 3'b010;
        pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("play_pout", a_pout, 1);
        pdone = 1'b1;
        @(negedge clk);
        pdone = 1'b0;
        chk("done_pulse", a_done, 3'b010);
        chk("done_grant_clr", a_grant, 0);
        cnt = 1;
        ones = 1;
        silent = (a_pout == 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_grant != 3'b000) break;
            cnt++;
            if (a_done != 3'b000) ones++;
            if (a_pout) silent = 1'b0;
        end
        chk("guard_len", cnt, G + 1);
        chk("guard_silent", silent, 1);
        chk("done_once", ones, 1);
        chk("regrant", a_grant, 3'b010);
        chk("regrant_bs", a_bs, bs[255:128]);

        // drop mid-play: drain silences, abort pulse on player_done
        do_reset();
        rand_data();
        req = 3'b100;
        pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("drop_pout_play", a_pout, 1);
        req = 3'b000;
        @(negedge clk);
        chk("drain_pout", a_pout, 0);
        chk("drain_grant", a_grant, 3'b100);
        repeat (2) @(negedge clk);
        chk("drain_grant_hold", a_grant, 3'b100);
        pdone = 1'b1;
        @(negedge clk);
        pdone = 1'b0;
        chk("abort_pulse", a_abort, 3'b100);
        chk("abort_no_done", a_done, 0);
        chk("abort_grant_clr", a_grant, 0);
        @(negedge clk);
        chk("abort_once", a_abort, 0);

        // all requesting, zero guard: order depends on round-robin build
        exp_rr[0] = 3'b001;
        exp_rr[1] = RR ? 3'b010 : 3'b001;
        exp_rr[2] = RR ? 3'b100 : 3'b001;
        exp_rr[3] = 3'b001;
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(1'b1, "rr");
            chk("rr_grant", b_grant, exp_rr[i]);
            repeat (2) @(negedge clk);
            pdone = 1'b1;
            @(negedge clk);
            pdone = 1'b0;
            chk("rr_done", b_done, exp_rr[i]);
        end

        // reset mid-play
        do_reset();
        rand_data();
        req = 3'b001;
        pin = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_grant", a_grant, 0);
        chk("mrst_start", a_start, 0);
        chk("mrst_bs", a_bs, 0);
        chk("mrst_len", a_len, 0);
        chk("mrst_gap", a_gap, 0);
        chk("mrst_pout", a_pout, 0);
        req = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        pdone = 1'b1;
        @(negedge clk);
        pdone = 1'b0;
        silent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (a_done != 0 || a_abort != 0) silent = 1'b0;
            @(negedge clk);
        end
        chk("mrst_no_pulse", silent, 1);

        // idle player in the first play cycle counts as done
        do_reset();
        busy = 1'b0;
        req = 3'b001;
        repeat (3) @(negedge clk);
        chk("nobusy_done", a_done, 3'b001);
        chk("nobusy_grant", a_grant, 0);
        busy = 1'b1;

        // timing inputs changed mid-play are ignored until the next win
        do_reset();
        rand_data();
        req = 3'b010;
        repeat (3) @(negedge clk);
        saved = dit[63:32];
        dit = ~dit;
        @(negedge clk);
        chk("dit_hold", a_dit, saved);
        pdone = 1'b1;
        @(negedge clk);
        pdone = 1'b0;
        wait_grant(1'b0, "dit");
        chk("dit_new", a_dit, dit[63:32]);

        // randomized transactions against the scanning model
        do_reset();
        ptr = 0;
        for (int t = 0; t < 30; t++) begin
            rand_data();
            r = 3'($urandom_range(1, 7));
            w = pick(r, RR ? ptr : 0);
            req = r;
            @(negedge clk);
            chk("rnd_grant", a_grant, 3'b001 << w);
            chk("rnd_bs", a_bs, bs[w*128 +: 128]);
            chk("rnd_gap", a_gap, gap[w*32 +: 32]);
            saved = dit[w*32 +: 32];
            ptr = (w + 1) % 3;
            repeat (2) @(negedge clk);
            dit = {$urandom, $urandom, $urandom};
            mode = $urandom_range(0, 1);
            k = $urandom_range(0, 4);
            if (mode == 1) begin
                req = r & ~(3'b001 << w);
                for (int i = 0; i <= k; i++) begin
                    pin = 1'b1;
                    @(negedge clk);
                    chk("rnd_drain_pout", a_pout, 0);
                end
                pdone = 1'b1;
                @(negedge clk);
                pdone = 1'b0;
                chk("rnd_abort", a_abort, 3'b001 << w);
                chk("rnd_abort_nodone", a_done, 0);
            end else begin
                for (int i = 0; i < k; i++) begin
                    pin = 1'($urandom_range(0, 1));
                    #1;
                    chk("rnd_play_pout", a_pout, pin);
                    @(negedge clk);
                end
                pdone = 1'b1;
                @(negedge clk);
                pdone = 1'b0;
                chk("rnd_done", a_done, 3'b001 << w);
                chk("rnd_done_noabort", a_abort, 0);
            end
            chk("rnd_grant_clr", a_grant, 0);
            chk("rnd_dit_hold", a_dit, saved);
            req = 3'b000;
            repeat (G + 2) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
